// File: rtl/rr_arb_1hot_pkg.sv
// Shared arbiter definitions: FSM state encoding and one-hot to binary index helper.
// Latency: none (constants and a combinational function only).
// Backpressure: not applicable.
package rr_arb_pkg;

  // Arbiter FSM encoding: idle (no grant held) or a grant held until release.
  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_GRANT = 1'b1;

  // Widest one-hot vector the helper accepts; narrower callers zero-extend.
  localparam int unsigned ONEHOT_MAX_W = 32;

  // OR-combines the indices of all set bits. For a one-hot input this is the
  // exact index, and an all-zero input yields 0. This avoids a priority chain.
  function automatic int unsigned onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      if (oh[i]) begin
        idx = idx | int'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_1hot_pick.sv
// Cyclic priority pick: first unmasked request at or after ptr, as a one-hot vector.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module rr_pick_1hot
  import rr_arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             any
);

  logic [N-1:0] eligible;
  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;

  // Rotate so that ptr lands on bit 0, isolate the lowest set bit, rotate back.
  // Duplicating the vector turns the cyclic rotation into a plain shift.
  always_comb begin
    eligible = req & ~mask;
    rot      = N'({eligible, eligible} >> ptr);
    rot_oh   = rot & (~rot + N'(1));
    win      = N'(({rot_oh, rot_oh} << ptr) >> N);
    any      = |eligible;
  end

endmodule

// File: rtl/rr_arb_1hot.sv
// Round-robin arbiter with packet lock; its registered one-hot grant drives a one-hot mux sel.
// Latency: 1 cycle from req to gnt; on release the next winner is granted at the same edge.
// Backpressure: out_ready low stalls the held grant; other requests never preempt it.
module rr_arb_1hot
  import rr_arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     last,
  input  logic             out_ready,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             err
);

  logic             state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [PTR_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             err_q, err_d;

  logic             cur_req;
  logic             cur_last;
  logic             xfer;
  logic             rel_last;
  logic             rel_drop;
  logic             do_rel;
  logic [PTR_W-1:0] ptr_rel;

  logic [N-1:0]     pick_mask;
  logic [PTR_W-1:0] pick_ptr;
  logic [N-1:0]     pick_win;
  logic             pick_any;
  logic [PTR_W-1:0] pick_idx;

  // Qualify the held grant against the live request/last of its own source.
  always_comb begin
    cur_req  = |(req & gnt_q);
    cur_last = |(last & gnt_q);
    xfer     = gnt_valid_q & out_ready & cur_req;
    rel_last = (state_q == ARB_GRANT) & xfer & cur_last;
    rel_drop = (state_q == ARB_GRANT) & ~cur_req;
    do_rel   = rel_last | rel_drop;
    ptr_rel  = (gnt_idx_q == PTR_W'(N - 1)) ? '0 : gnt_idx_q + PTR_W'(1);
  end

  // Arbitrate from the stored pointer when idle; on release, from the advanced
  // pointer with the departing source masked so it cannot win twice in a row.
  always_comb begin
    pick_mask = '0;
    pick_ptr  = ptr_q;
    if (state_q == ARB_GRANT) begin
      pick_mask = gnt_q;
      pick_ptr  = ptr_rel;
    end
  end

  rr_pick_1hot #(.N(N)) u_pick (
    .req  (req),
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .win  (pick_win),
    .any  (pick_any)
  );

  // Index derived from the same one-hot winner so gnt and gnt_idx never disagree.
  always_comb begin
    pick_idx = PTR_W'(onehot_to_idx(ONEHOT_MAX_W'(pick_win)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave IDLE on any request; leave GRANT only on a release with nobody waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (do_rel && !pick_any) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs and pointer; everything holds unless
  // a new grant is taken from IDLE or the current grant is released.
  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    err_d       = err_q | rel_drop;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_win;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = pick_idx;
        end
      end
      ARB_GRANT: begin
        if (do_rel) begin
          ptr_d       = ptr_rel;
          gnt_d       = pick_win;
          gnt_valid_d = pick_any;
          gnt_idx_d   = pick_idx;
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
      end
    endcase
  end

  // Datapath registers; reset drops any grant immediately, mid-packet included.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      err_q       <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign err       = err_q;

  // The downstream mux relies on these; a violation means corrupted select.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_valid   : assert property (@(posedge clk) disable iff (rst) gnt_valid_q == (|gnt_q));

endmodule

// File: tb/tb_rr_arb_1hot.sv
module tb_rr_arb_1hot;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic         out_ready;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arb_1hot #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .err       (err)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] egnt;
    logic [1:0] eidx;
    logic       eerr;
    logic [1:0] eptr;
  } vec_t;

  localparam int NV = 31;
  vec_t vec [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] l,
                              input logic o, input logic [3:0] g, input logic [1:0] i,
                              input logic e, input logic [1:0] p);
    vec_t v;
    v.rst  = r;
    v.req  = q;
    v.last = l;
    v.ordy = o;
    v.egnt = g;
    v.eidx = i;
    v.eerr = e;
    v.eptr = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] src_req;
    logic [N-1:0] pre_gnt;
    logic [N-1:0] xl;
    logic [1:0]   ei;
    int           wait_cnt [N];

    rst       = 1'b1;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;

    //           rst  req      last     rdy  gnt      idx err ptr
    // reset, then a single-beat packet from source 2
    vec[0]  = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    vec[1]  = mk(0, 4'b0100, 4'b1111, 1, 4'b0100, 2, 0, 0);
    vec[2]  = mk(0, 4'b0100, 4'b1111, 1, 4'b0000, 0, 0, 3);
    vec[3]  = mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 0, 3);
    // all request single beats: strict rotation, no bubbles
    vec[4]  = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    vec[5]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0);
    vec[6]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 1);
    vec[7]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 2, 0, 2);
    vec[8]  = mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 0, 3);
    vec[9]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0);
    vec[10] = mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 1);
    vec[11] = mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 2, 0, 2);
    vec[12] = mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 0, 3);
    // 3-beat packet from source 1 with stalls, then same-edge handover to 0
    vec[13] = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    vec[14] = mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 0, 0);
    vec[15] = mk(0, 4'b0011, 4'b0000, 1, 4'b0010, 1, 0, 0);
    vec[16] = mk(0, 4'b0011, 4'b0000, 0, 4'b0010, 1, 0, 0);
    vec[17] = mk(0, 4'b0011, 4'b0000, 1, 4'b0010, 1, 0, 0);
    vec[18] = mk(0, 4'b0011, 4'b0000, 0, 4'b0010, 1, 0, 0);
    vec[19] = mk(0, 4'b0011, 4'b0010, 1, 4'b0001, 0, 0, 2);
    // request dropped mid-packet: sticky err, grant moves on or goes idle
    vec[20] = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    vec[21] = mk(0, 4'b1000, 4'b0000, 0, 4'b1000, 3, 0, 0);
    vec[22] = mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, 1, 0);
    vec[23] = mk(0, 4'b0001, 4'b0001, 1, 4'b0000, 0, 1, 1);
    vec[24] = mk(0, 4'b1000, 4'b0000, 0, 4'b1000, 3, 1, 1);
    vec[25] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0);
    // reset mid-packet clears grant, err and pointer
    vec[26] = mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 0);
    vec[27] = mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 0);
    vec[28] = mk(1, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0);
    vec[29] = mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, 0, 0);
    vec[30] = mk(0, 4'b1111, 4'b0001, 1, 4'b0010, 1, 0, 1);

    for (int v = 0; v < NV; v++) begin
      rst       = vec[v].rst;
      req       = vec[v].req;
      last      = vec[v].last;
      out_ready = vec[v].ordy;
      tick();
      check($sformatf("v%0d gnt", v), 32'(gnt), 32'(vec[v].egnt));
      check($sformatf("v%0d gnt_idx", v), 32'(gnt_idx), 32'(vec[v].eidx));
      check($sformatf("v%0d gnt_valid", v), 32'(gnt_valid), 32'(vec[v].egnt != 4'b0000));
      check($sformatf("v%0d err", v), 32'(err), 32'(vec[v].eerr));
      check($sformatf("v%0d ptr", v), 32'(dut.ptr_q), 32'(vec[v].eptr));
    end

    // Randomised protocol-compliant sources: each holds req until its last beat transfers.
    rst       = 1'b1;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;
    tick();
    rst     = 1'b0;
    src_req = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!src_req[i] && $urandom_range(0, 2) == 0) src_req[i] = 1'b1;
      end
      req       = src_req;
      last      = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      pre_gnt   = gnt;
      tick();
      xl = pre_gnt & req & last & {N{out_ready}};

      check("rand onehot0", 32'($onehot0(gnt)), 32'd1);
      check("rand valid", 32'(gnt_valid), 32'(gnt != '0));
      ei = '0;
      for (int i = 0; i < N; i++) if (gnt[i]) ei = 2'(i);
      check("rand idx", 32'(gnt_idx), 32'(ei));
      check("rand err", 32'(err), 32'd0);
      if (pre_gnt != '0 && xl == '0) check("rand hold", 32'(gnt), 32'(pre_gnt));
      if (pre_gnt == '0 && req != '0) check("rand idle grant", 32'(gnt != '0), 32'd1);
      if (xl != '0 && (req & ~pre_gnt) != '0) check("rand back2back", 32'(gnt != '0), 32'd1);

      if (gnt != '0 && gnt != pre_gnt) begin
        for (int i = 0; i < N; i++) begin
          if (gnt[i]) begin
            wait_cnt[i] = 0;
          end else if (req[i] && !xl[i]) begin
            wait_cnt[i]++;
            check($sformatf("rand fair src%0d", i), 32'(wait_cnt[i] < N), 32'd1);
          end
        end
      end
      src_req = src_req & ~xl;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_1hot.md
Name: rr_arb_1hot

Overview:
- Round-robin arbiter with packet lock. Sits directly upstream of the one-hot mux.
- Its registered one-hot grant drives the mux `sel` input, so `sel` is always one-hot or all-zero by construction.
- Holds a grant across a multi-beat transfer until the granted source's last beat is accepted downstream.

Parameters:
- N, 8, number of requesters (2..32); also the one-hot grant width.
- PTR_W, $clog2(N), width of the round-robin pointer (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N  per-source request; held high by a source until its last beat transfers.
- last  input  N  per-source end-of-packet flag; only the bit of the granted source is sampled.
- out_ready  input  1  downstream accepts the current beat.
- gnt  output  N  registered one-hot grant (mux select); all-zero when idle.
- gnt_valid  output  1  registered; high iff gnt is non-zero.
- gnt_idx  output  PTR_W  binary index of the granted source; 0 when idle.
- err  output  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at an edge):
  - gnt=0, gnt_valid=0, gnt_idx=0, err=0.
  - ptr=0, state=IDLE.
  - Applies mid-transfer too: grant is dropped at that edge, with no completion of the packet.
- States are IDLE and GRANT.
  - The highest-priority candidate is the first set req bit at or after ptr, searched cyclically (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
- IDLE:
  - If |req, go to GRANT and register gnt = one-hot(winner). This gives 1 cycle latency from req to gnt.
  - Otherwise remain in IDLE.
- GRANT:
  - A beat transfers when gnt_valid & out_ready & req[gnt_idx].
  - Transfer with last[gnt_idx]=1 (release):
    - ptr <= gnt_idx+1, wrapping from N-1 to 0.
    - The next winner is computed from the updated ptr with req[gnt_idx] masked.
    - If a winner exists, grant it at the same edge (back-to-back, no bubble cycle). Otherwise gnt=0 and go to IDLE.
  - Transfer with last=0: hold the grant.
  - No transfer: hold the grant. Changes on other sources' req never preempt.
  - req[gnt_idx] drops without a last transfer:
    - Set err=1, release the grant as if last had transferred, and advance ptr.
    - No beat is counted.
- ptr updates only on release.
  - Fairness: with all sources requesting single-beat packets, grants rotate 0,1,...,N-1,0.
- Simultaneous release and new requests: newly asserted req bits participate in the same-edge arbitration.
- gnt_idx and gnt are updated together from the same winner and always agree.
- The combinational path is limited to the priority pick. gnt has no combinational path from req or out_ready.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state encoding constants ARB_IDLE=1'b0 and ARB_GRANT=1'b1;
  - a one-hot-to-index function, reused by other one-hot consumers.
- One sub-module, rr_pick_1hot(N): purely combinational.
  - Inputs are req, mask, and ptr; outputs are the one-hot winner and an any flag.
  - It is verified standalone with exhaustive req×ptr for N=4.

Test Plan (N=4):
- Reset, then req=4'b0100 with out_ready=1 and last=1 → gnt=4'b0100 and gnt_idx=2 one cycle later. Release after 1 beat; next edge gnt=0 and gnt_valid=0; ptr=3.
- req=4'b1111, last=4'b1111, out_ready=1 held for 8 cycles → gnt sequence 0001,0010,0100,1000,0001,..., one grant per cycle, no idle cycles.
- Source 1 sends a 3-beat packet (last on beat 3) while req=4'b0011, with out_ready toggling 1,0,1,0,1 → gnt stays 4'b0010 until the third transfer, then moves to 4'b0001 at the same edge.
- Under a grant to source 3, deassert req[3] with last=0 → err=1 next edge; grant moves to the next requester, or to 0 if there is none; err stays 1 until rst.
- Assert rst mid-packet while gnt=4'b0100 → next edge gnt=0, gnt_valid=0, err=0, ptr=0. After deassertion with req=4'b1111, the first grant is 4'b0001.
- Random req/last/out_ready for 10k cycles with a scoreboard → gnt is always one-hot or zero, gnt_idx is consistent with gnt, no grant change mid-packet, and every requester is served within N packets.
